// File: rtl/unidad_riesgos.sv
// Hazard/forwarding controller for the vector pipeline: load-use stall FSM,
// branch flush, per-operand forwarding selects and a saturating stall counter.
module unidad_riesgos #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       rs1_id,
  input  logic [2:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic             vec_id,
  input  logic [2:0]       dir_dest_ex,
  input  logic             reg_wrv_ex,
  input  logic             reg_wrs_ex,
  input  logic             sel_mem_ex,
  input  logic [2:0]       dir_dest_mem,
  input  logic             reg_wrv_mem,
  input  logic             reg_wrs_mem,
  input  logic             sel_pcmem_mem,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t     state, eff_state, next_state;
  logic [2:0] lat_cnt, lat_nxt;
  logic       wr_ex, wr_mem;
  logic       hit1_ex, hit2_ex, hit1_mem, hit2_mem;
  logic       load_use;

  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem,
                                         input logic is_load);
    if (hit_ex && !is_load) return 2'b01;
    else if (hit_mem)       return 2'b10;
    else                    return 2'b00;
  endfunction

  always_comb begin
    wr_ex    = vec_id ? reg_wrv_ex  : reg_wrs_ex;
    wr_mem   = vec_id ? reg_wrv_mem : reg_wrs_mem;
    hit1_ex  = use_rs1_id & wr_ex  & (rs1_id == dir_dest_ex);
    hit2_ex  = use_rs2_id & wr_ex  & (rs2_id == dir_dest_ex);
    hit1_mem = use_rs1_id & wr_mem & (rs1_id == dir_dest_mem);
    hit2_mem = use_rs2_id & wr_mem & (rs2_id == dir_dest_mem);
    load_use = sel_mem_ex & (hit1_ex | hit2_ex);
  end

  // A taken branch is acted on in the same cycle it appears, so FLUSH is the
  // effective state for that cycle and the registered state returns to RUN.
  always_comb begin
    eff_state  = sel_pcmem_mem ? FLUSH : state;
    next_state = state;
    lat_nxt    = lat_cnt;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    bubble_ex  = 1'b0;
    flush_id   = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    unique case (eff_state)
      RUN: begin
        fwd_a = fwd_sel(hit1_ex, hit1_mem, sel_mem_ex);
        fwd_b = fwd_sel(hit2_ex, hit2_mem, sel_mem_ex);
        if (load_use) begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          bubble_ex  = 1'b1;
          next_state = STALL;
          lat_nxt    = 3'(LOAD_LAT - 1);
        end
      end
      STALL: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
        if (lat_cnt == '0) next_state = RUN;
        else               lat_nxt    = lat_cnt - 3'd1;
      end
      FLUSH: begin
        flush_id   = 1'b1;
        bubble_ex  = 1'b1;
        next_state = RUN;
        lat_nxt    = '0;
      end
      default: begin
        next_state = RUN;
        lat_nxt    = '0;
      end
    endcase
    if (!rst_n) begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      bubble_ex = 1'b0;
      flush_id  = 1'b0;
      fwd_a     = 2'b00;
      fwd_b     = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      lat_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      state   <= next_state;
      lat_cnt <= lat_nxt;
      if (stall_if && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_unidad_riesgos.sv
module tb_unidad_riesgos;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rs1_id, rs2_id, dir_dest_ex, dir_dest_mem;
  logic       use_rs1_id, use_rs2_id, vec_id;
  logic       reg_wrv_ex, reg_wrs_ex, sel_mem_ex;
  logic       reg_wrv_mem, reg_wrs_mem, sel_pcmem_mem;

  logic        si0, sid0, bub0, fl0, si1, sid1, bub1, fl1;
  logic [1:0]  fa0, fb0, fa1, fb1;
  logic [15:0] cnt0, cnt1;

  always #5 clk = ~clk;

  unidad_riesgos #(.LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .vec_id(vec_id),
    .dir_dest_ex(dir_dest_ex), .reg_wrv_ex(reg_wrv_ex), .reg_wrs_ex(reg_wrs_ex),
    .sel_mem_ex(sel_mem_ex), .dir_dest_mem(dir_dest_mem), .reg_wrv_mem(reg_wrv_mem),
    .reg_wrs_mem(reg_wrs_mem), .sel_pcmem_mem(sel_pcmem_mem),
    .stall_if(si0), .stall_id(sid0), .bubble_ex(bub0), .flush_id(fl0),
    .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(cnt0));

  unidad_riesgos #(.LOAD_LAT(3), .CNT_W(16)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .vec_id(vec_id),
    .dir_dest_ex(dir_dest_ex), .reg_wrv_ex(reg_wrv_ex), .reg_wrs_ex(reg_wrs_ex),
    .sel_mem_ex(sel_mem_ex), .dir_dest_mem(dir_dest_mem), .reg_wrv_mem(reg_wrv_mem),
    .reg_wrs_mem(reg_wrs_mem), .sel_pcmem_mem(sel_pcmem_mem),
    .stall_if(si1), .stall_id(sid1), .bubble_ex(bub1), .flush_id(fl1),
    .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(cnt1));

  int          total = 0;
  int          bad = 0;
  string       tag_q[$];
  logic [23:0] v_q[$];
  bit          d_q[$];

  function automatic logic [23:0] mk(logic si, logic sid, logic bub, logic fl,
                                     logic [1:0] fa, logic [1:0] fb, logic [15:0] c);
    return {si, sid, bub, fl, fa, fb, c};
  endfunction

  task automatic chk(string t, bit d, logic [23:0] v);
    tag_q.push_back(t);
    d_q.push_back(d);
    v_q.push_back(v);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rs1_id = 3'd0; rs2_id = 3'd0; use_rs1_id = 1'b0; use_rs2_id = 1'b0; vec_id = 1'b0;
    dir_dest_ex = 3'd0; reg_wrv_ex = 1'b0; reg_wrs_ex = 1'b0; sel_mem_ex = 1'b0;
    dir_dest_mem = 3'd0; reg_wrv_mem = 1'b0; reg_wrs_mem = 1'b0; sel_pcmem_mem = 1'b0;
  endtask

  task automatic load_use_s3;
    idle;
    sel_mem_ex = 1'b1; reg_wrs_ex = 1'b1; dir_dest_ex = 3'd3;
    use_rs1_id = 1'b1; rs1_id = 3'd3;
  endtask

  always @(negedge clk) begin
    while (v_q.size() > 0) begin
      string       t;
      bit          d;
      logic [23:0] e, got;
      t = tag_q.pop_front();
      d = d_q.pop_front();
      e = v_q.pop_front();
      got = d ? {si1, sid1, bub1, fl1, fa1, fb1, cnt1}
              : {si0, sid0, bub0, fl0, fa0, fb0, cnt0};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s dut=%0d got=%h exp=%h", t, d, got, e);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle;
    step; load_use_s3; chk("rst_hazard_l1", 0, '0); chk("rst_hazard_l3", 1, '0);
    step; rst_n = 1'b1; idle; chk("rst_release", 0, '0);

    step; load_use_s3;
    chk("lu_detect", 0, mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 16'd0));
    step; idle; dir_dest_mem = 3'd3; reg_wrs_mem = 1'b1; use_rs1_id = 1'b1; rs1_id = 3'd3;
    chk("lu_stall", 0, mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 16'd1));
    step; chk("lu_resume_fwd_mem", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 16'd2));

    step; idle; vec_id = 1'b1; reg_wrv_ex = 1'b1; dir_dest_ex = 3'd2;
    reg_wrv_mem = 1'b1; dir_dest_mem = 3'd2; use_rs2_id = 1'b1; rs2_id = 3'd2; rs1_id = 3'd2;
    chk("fwd_b_ex", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 16'd2));
    step; use_rs1_id = 1'b1;
    chk("fwd_ab_ex", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 16'd2));
    step; vec_id = 1'b0;
    chk("fwd_scalar_miss", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd2));

    step; idle; reg_wrs_mem = 1'b1; dir_dest_mem = 3'd5;
    use_rs1_id = 1'b1; rs1_id = 3'd5; use_rs2_id = 1'b1; rs2_id = 3'd5;
    chk("fwd_mem_scalar", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 16'd2));
    step; vec_id = 1'b1;
    chk("fwd_vec_mismatch", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd2));
    step; idle; reg_wrs_ex = 1'b1; dir_dest_ex = 3'd0; reg_wrs_mem = 1'b1; dir_dest_mem = 3'd0;
    use_rs1_id = 1'b1; rs1_id = 3'd0; use_rs2_id = 1'b1; rs2_id = 3'd1;
    chk("fwd_r0_ex_prio", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 16'd2));

    step; idle; sel_mem_ex = 1'b1; reg_wrv_ex = 1'b1; dir_dest_ex = 3'd6;
    vec_id = 1'b1; use_rs2_id = 1'b1; rs2_id = 3'd6;
    chk("lu_rs2_vec", 0, mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 16'd2));
    step; idle; sel_pcmem_mem = 1'b1;
    chk("br_in_stall", 0, mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 16'd3));
    step; idle; chk("after_flush", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd3));
    step; load_use_s3; sel_pcmem_mem = 1'b1;
    chk("br_beats_lu", 0, mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 16'd3));
    step; load_use_s3;
    chk("run_after_br", 0, mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 16'd3));
    step; idle; chk("stall_after_br", 0, mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 16'd4));
    step; chk("idle_l1", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd5));

    step; rst_n = 1'b0; idle; chk("rst2_l3", 1, '0);
    step; rst_n = 1'b1; chk("rst2_rel_l3", 1, '0);
    step; load_use_s3;
    chk("l3_detect", 1, mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 16'd0));
    step; idle; sel_pcmem_mem = 1'b1;
    chk("l3_flush", 1, mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 16'd1));
    step; idle; chk("l3_run", 1, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd1));
    step; load_use_s3;
    chk("l3_full_detect", 1, mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 16'd1));
    for (int k = 0; k < 3; k++) begin
      step; idle;
      chk($sformatf("l3_full_stall%0d", k), 1,
          mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 16'(k + 2)));
    end
    step; chk("l3_full_done", 1, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd5));

    step; load_use_s3;
    chk("l3_pre_rst", 1, mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 16'd5));
    step; idle; chk("l3_pre_rst_stall", 1, mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 16'd6));
    step; load_use_s3; rst_n = 1'b0; chk("rst_mid_l3", 1, '0); chk("rst_mid_l1", 0, '0);
    step; rst_n = 1'b1; idle; chk("rst_mid_rel", 1, '0);
    step; chk("rst_no_residual", 1, '0);

    for (int h = 0; h < 70000; h++) begin
      step;
      if (h == 0) load_use_s3;
      if (h == 0 || h == 1 || h == 100 || h == 65534 || h == 65535 || h == 69999)
        chk($sformatf("sat_l1_h%0d", h), 0,
            mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 16'((h < 65535) ? h : 65535)));
      if (h == 69999)
        chk("sat_l3", 1, mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 16'hFFFF));
    end
    step; idle;
    chk("sat_hold_l1", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'hFFFF));
    chk("sat_hold_l3", 1, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'hFFFF));
    step;
    step;
    total++;
    if (cnt0 !== 16'hFFFF) begin
      bad++;
      $display("FAIL final_cnt_l1 got=%h exp=ffff", cnt0);
    end
    total++;
    if (cnt1 !== 16'hFFFF) begin
      bad++;
      $display("FAIL final_cnt_l3 got=%h exp=ffff", cnt1);
    end
    total++;
    if (si0 !== 1'b0) begin
      bad++;
      $display("FAIL final_si_l1 got=%b exp=0", si0);
    end
    total++;
    if (si1 !== 1'b0) begin
      bad++;
      $display("FAIL final_si_l3 got=%b exp=0", si1);
    end
    total++;
    if (fl1 !== 1'b0) begin
      bad++;
      $display("FAIL final_fl_l3 got=%b exp=0", fl1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
